madd_stream: RTL

- Streaming, pipelined successor to the flat combinational matrix adder.
- Performs the residual element-wise add of two ROWS x DIMENTION signed matrices, LANES elements per beat, over valid/ready handshakes.
- Adds a saturate/wrap mode, overflow reporting, row/matrix framing and a start/done job controller.
- Sits between the attention/FFN output buffers and the layer-norm input stream.

---
 rtl/madd_stream.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/madd_stream.sv
// Streaming residual adder: element-wise a1+a2 of two ROWS x DIMENTION signed matrices,
// LANES elements per beat, with saturate/wrap mode, overflow flags, row/matrix framing and a job controller.
module madd_stream #(
   parameter int unsigned LANES        = 16,
   parameter int unsigned DIMENTION    = 768,
   parameter int unsigned ROWS         = 128,
   parameter int unsigned WIDTH_ADDEND = 32,
   parameter int unsigned WIDTH_SUM    = WIDTH_ADDEND
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          sat_mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*WIDTH_ADDEND-1:0] addend1,
   input  logic [LANES*WIDTH_ADDEND-1:0] addend2,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*WIDTH_SUM-1:0]    sum,
   output logic                          out_last_row,
   output logic                          out_last,
   output logic                          ovf_beat,
   output logic                          ovf_sticky,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned BEATS = DIMENTION / LANES;
   localparam int unsigned COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned OUT_W = LANES * WIDTH_SUM;
   localparam int unsigned S_W   = WIDTH_ADDEND + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               state;
   logic                 sat_q;
   logic [COL_W-1:0]     col;
   logic [ROW_W-1:0]     row;
   logic                 accept;
   logic                 take;
   logic                 col_last;
   logic                 row_last;
   logic [OUT_W-1:0]     sum_next;
   logic [LANES-1:0]     lane_ovf;

   // Single output register: a new beat may enter whenever the register is empty or being drained.
   assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign take     = out_valid && out_ready;
   assign col_last = (col == COL_W'(BEATS - 1));
   assign row_last = (row == ROW_W'(ROWS - 1));
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [S_W-1:0]    s;
      logic                     ovf;
      logic [WIDTH_SUM-1:0]     ext;
      logic [WIDTH_SUM-1:0]     clamp;

      assign s = S_W'($signed(addend1[i*WIDTH_ADDEND +: WIDTH_ADDEND]))
               + S_W'($signed(addend2[i*WIDTH_ADDEND +: WIDTH_ADDEND]));

      // A wider result holds every possible sum, so only the equal-width case can overflow.
      if (WIDTH_SUM > WIDTH_ADDEND) begin : g_wide
         assign ovf = 1'b0;
         assign ext = WIDTH_SUM'(s);
      end else begin : g_same
         assign ovf = s[S_W-1] ^ s[S_W-2];
         assign ext = WIDTH_SUM'(s[S_W-2:0]);
      end

      assign clamp = s[S_W-1] ? {1'b1, {(WIDTH_SUM-1){1'b0}}}
                              : {1'b0, {(WIDTH_SUM-1){1'b1}}};
      assign lane_ovf[i] = ovf;
      assign sum_next[i*WIDTH_SUM +: WIDTH_SUM] = (ovf && sat_q) ? clamp : ext;
   end

   // Job FSM, beat counters and the output register.
   always_ff @(posedge clk) begin : p_main
      if (!rst_n) begin
         state        <= ST_IDLE;
         sat_q        <= 1'b0;
         col          <= '0;
         row          <= '0;
         out_valid    <= 1'b0;
         sum          <= '0;
         out_last_row <= 1'b0;
         out_last     <= 1'b0;
         ovf_beat     <= 1'b0;
         ovf_sticky   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_RUN;
                  sat_q      <= sat_mode;
                  ovf_sticky <= 1'b0;
                  col        <= '0;
                  row        <= '0;
               end
            end
            ST_RUN: begin
               if (accept && col_last && row_last) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (take && out_last) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (accept) begin
            col          <= col_last ? '0 : col + COL_W'(1);
            if (col_last) begin
               row <= row_last ? '0 : row + ROW_W'(1);
            end
            out_valid    <= 1'b1;
            sum          <= sum_next;
            out_last_row <= col_last;
            out_last     <= col_last && row_last;
            ovf_beat     <= |lane_ovf;
            ovf_sticky   <= ovf_sticky | (|lane_ovf);
         end else if (take) begin
            out_valid    <= 1'b0;
         end
      end
   end

endmodule
